alu_reservation_station: RTL and testbench

- Receiving end of the ALU dispatch path: holds ALU-class instructions (R/I-type ALU ops, LUI, AUIPC) after decode until both operands are available.
- Snoops the common data bus (CDB) for pending operand tags.
- Issues ready entries to the ALU functional unit.
- Releases each entry only when its own result tag is broadcast on the CDB.

---
 rtl/alu_reservation_station.sv | 190 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module  : alu_reservation_station
// Brief   : ALU reservation station with CDB wakeup, lowest-index select and
//           release on own-tag broadcast.
// Rev     : 1.0  initial release
// ============================================================================
module alu_reservation_station #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_alu_op,
    input  logic [31:0]      disp_vj,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_qk,
    output logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [3:0]       iss_alu_op,
    output logic [31:0]      iss_a,
    output logic [31:0]      iss_b,
    output logic [TAG_W-1:0] iss_tag
);

    localparam int         c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] c_st_free   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_issued = 2'd2;

    logic [1:0]       r_state [DEPTH];
    logic [3:0]       r_op    [DEPTH];
    logic [31:0]      r_vj    [DEPTH];
    logic [31:0]      r_vk    [DEPTH];
    logic [TAG_W-1:0] r_qj    [DEPTH];
    logic [TAG_W-1:0] r_qk    [DEPTH];

    logic [1:0]       w_state_nxt [DEPTH];
    logic [3:0]       w_op_nxt    [DEPTH];
    logic [31:0]      w_vj_nxt    [DEPTH];
    logic [31:0]      w_vk_nxt    [DEPTH];
    logic [TAG_W-1:0] w_qj_nxt    [DEPTH];
    logic [TAG_W-1:0] w_qk_nxt    [DEPTH];

    logic [DEPTH-1:0]   w_free;
    logic [DEPTH-1:0]   w_ready;
    logic               w_free_any;
    logic               w_ready_any;
    logic [c_idx_w-1:0] w_alloc_idx;
    logic [c_idx_w-1:0] w_sel_idx;
    logic               w_accept;
    logic               w_issue;
    logic               w_cdb_hit;
    logic               w_byp_j;
    logic               w_byp_k;
    logic [31:0]        w_vj_in;
    logic [31:0]        w_vk_in;
    logic [TAG_W-1:0]   w_qj_in;
    logic [TAG_W-1:0]   w_qk_in;

    // READY is not stored: it is a WAIT entry whose operand tags are both clear
    for (genvar g = 0; g < DEPTH; g++) begin : g_flags
        assign w_free[g]  = (r_state[g] == c_st_free);
        assign w_ready[g] = (r_state[g] == c_st_wait) && (r_qj[g] == '0) && (r_qk[g] == '0);
    end

    assign w_free_any  = |w_free;
    assign w_ready_any = |w_ready;

    always_comb begin
        w_alloc_idx = '0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_free[i])  w_alloc_idx = c_idx_w'(i);
            if (w_ready[i]) w_sel_idx   = c_idx_w'(i);
        end
    end

    assign disp_ready = w_free_any;
    assign disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_alloc_idx);
    assign w_accept   = disp_valid && w_free_any && !flush;
    assign w_issue    = w_ready_any && iss_ready;
    assign w_cdb_hit  = cdb_valid && (cdb_tag != '0);

    // A producer broadcasting in the accept cycle would otherwise be missed
    assign w_byp_j = w_cdb_hit && (cdb_tag == disp_qj);
    assign w_byp_k = w_cdb_hit && (cdb_tag == disp_qk);
    assign w_vj_in = w_byp_j ? cdb_data : disp_vj;
    assign w_vk_in = w_byp_k ? cdb_data : disp_vk;
    assign w_qj_in = w_byp_j ? '0 : disp_qj;
    assign w_qk_in = w_byp_k ? '0 : disp_qk;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_st_free;
                r_op[i]    <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_op[i]    <= w_op_nxt[i];
                r_vj[i]    <= w_vj_nxt[i];
                r_vk[i]    <= w_vk_nxt[i];
                r_qj[i]    <= w_qj_nxt[i];
                r_qk[i]    <= w_qk_nxt[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_op_nxt[i]    = r_op[i];
            w_vj_nxt[i]    = r_vj[i];
            w_vk_nxt[i]    = r_vk[i];
            w_qj_nxt[i]    = r_qj[i];
            w_qk_nxt[i]    = r_qk[i];
            if (flush) begin
                w_state_nxt[i] = c_st_free;
                w_qj_nxt[i]    = '0;
                w_qk_nxt[i]    = '0;
            end else begin
                case (r_state[i])
                    c_st_free: begin
                        if (w_accept && (w_alloc_idx == c_idx_w'(i))) begin
                            w_state_nxt[i] = c_st_wait;
                            w_op_nxt[i]    = disp_alu_op;
                            w_vj_nxt[i]    = w_vj_in;
                            w_vk_nxt[i]    = w_vk_in;
                            w_qj_nxt[i]    = w_qj_in;
                            w_qk_nxt[i]    = w_qk_in;
                        end
                    end
                    c_st_wait: begin
                        if (w_cdb_hit && (r_qj[i] == cdb_tag)) begin
                            w_vj_nxt[i] = cdb_data;
                            w_qj_nxt[i] = '0;
                        end
                        if (w_cdb_hit && (r_qk[i] == cdb_tag)) begin
                            w_vk_nxt[i] = cdb_data;
                            w_qk_nxt[i] = '0;
                        end
                        if (w_issue && (w_sel_idx == c_idx_w'(i))) begin
                            w_state_nxt[i] = c_st_issued;
                        end
                    end
                    c_st_issued: begin
                        if (cdb_valid && (cdb_tag == TAG_W'(TAG_BASE + i))) begin
                            w_state_nxt[i] = c_st_free;
                        end
                    end
                    default: w_state_nxt[i] = c_st_free;
                endcase
            end
        end
    end

    // Output logic
    always_comb begin
        iss_valid  = w_ready_any;
        iss_alu_op = '0;
        iss_a      = '0;
        iss_b      = '0;
        iss_tag    = '0;
        if (w_ready_any) begin
            iss_alu_op = r_op[w_sel_idx];
            iss_a      = r_vj[w_sel_idx];
            iss_b      = r_vk[w_sel_idx];
            iss_tag    = TAG_W'(TAG_BASE) + TAG_W'(w_sel_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_reservation_station
// Brief   : Scoreboard bench for alu_reservation_station against an entry model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_reservation_station;

    localparam int DEPTH    = 4;
    localparam int TW       = 4;
    localparam int TAG_BASE = 1;

    logic          clk = 1'b0;
    logic          rst, flush, disp_valid, disp_ready;
    logic [3:0]    disp_alu_op;
    logic [31:0]   disp_vj, disp_vk;
    logic [TW-1:0] disp_qj, disp_qk, disp_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          iss_valid, iss_ready;
    logic [3:0]    iss_alu_op;
    logic [31:0]   iss_a, iss_b;
    logic [TW-1:0] iss_tag;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TW), .TAG_BASE(TAG_BASE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_op(disp_alu_op),
        .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_vk(disp_vk), .disp_qk(disp_qk),
        .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_op(iss_alu_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dr;
        logic [TW-1:0] dt;
        logic          iv;
        logic [3:0]    op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sq[$];   // expected outputs, one per cycle
    exp_t iq[$];   // expected accepted issues, in order

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model: a pool of slots, each either free or holding an instruction
    bit            m_busy   [DEPTH];
    bit            m_issued [DEPTH];
    logic [3:0]    m_op     [DEPTH];
    logic [31:0]   m_a      [DEPTH];
    logic [31:0]   m_b      [DEPTH];
    logic [TW-1:0] m_qa     [DEPTH];
    logic [TW-1:0] m_qb     [DEPTH];

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int first_ready();
        for (int i = 0; i < DEPTH; i++)
            if (m_busy[i] && !m_issued[i] && m_qa[i] == 0 && m_qb[i] == 0) return i;
        return -1;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int f = first_free();
        int s = first_ready();
        e.dr  = (f >= 0);
        e.dt  = TW'(TAG_BASE + ((f >= 0) ? f : 0));
        e.iv  = (s >= 0);
        e.op  = (s >= 0) ? m_op[s] : 4'd0;
        e.a   = (s >= 0) ? m_a[s]  : 32'd0;
        e.b   = (s >= 0) ? m_b[s]  : 32'd0;
        e.tag = (s >= 0) ? TW'(TAG_BASE + s) : '0;
        return e;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        int  f = first_free();
        int  s = first_ready();
        bit  hit = cdb_valid && (cdb_tag != 0);
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_busy[i] = 1'b0;
                m_issued[i] = 1'b0;
                m_qa[i] = '0;
                m_qb[i] = '0;
            end
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_issued[i]) begin
                if (cdb_valid && cdb_tag == TW'(TAG_BASE + i)) begin
                    m_busy[i] = 1'b0;
                    m_issued[i] = 1'b0;
                end
            end else if (m_busy[i] && hit) begin
                if (m_qa[i] == cdb_tag) begin m_a[i] = cdb_data; m_qa[i] = '0; end
                if (m_qb[i] == cdb_tag) begin m_b[i] = cdb_data; m_qb[i] = '0; end
            end
        end
        if (s >= 0 && iss_ready) m_issued[s] = 1'b1;
        if (f >= 0 && disp_valid) begin
            m_busy[f]   = 1'b1;
            m_issued[f] = 1'b0;
            m_op[f]     = disp_alu_op;
            m_a[f]      = (hit && cdb_tag == disp_qj) ? cdb_data : disp_vj;
            m_qa[f]     = (hit && cdb_tag == disp_qj) ? '0 : disp_qj;
            m_b[f]      = (hit && cdb_tag == disp_qk) ? cdb_data : disp_vk;
            m_qb[f]     = (hit && cdb_tag == disp_qk) ? '0 : disp_qk;
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic dv, input logic [3:0] op,
                         input logic [31:0] vj, input logic [TW-1:0] qj,
                         input logic [31:0] vk, input logic [TW-1:0] qk,
                         input logic cv, input logic [TW-1:0] ct, input logic [31:0] cd,
                         input logic ir);
        exp_t e;
        rst = r; flush = f; disp_valid = dv; disp_alu_op = op;
        disp_vj = vj; disp_qj = qj; disp_vk = vk; disp_qk = qk;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd; iss_ready = ir;
        e = model_outputs();
        sq.push_back(e);
        if (e.iv && ir) iq.push_back(e);
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle(input int n, input logic ir);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir);
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [31:0] d, input logic ir);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, t, d, ir);
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [TW-1:0] qj,
                        input logic [31:0] vk, input logic [TW-1:0] qk, input logic ir);
        drive(0, 0, 1, op, vj, qj, vk, qk, 0, 0, 0, ir);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && sq.size() > 0) begin
                e = sq.pop_front();
                check("disp_ready", 32'(disp_ready), 32'(e.dr));
                check("disp_tag",   32'(disp_tag),   32'(e.dt));
                check("iss_valid",  32'(iss_valid),  32'(e.iv));
                if (!e.iv) begin
                    check("idle_iss_a", iss_a, 32'd0);
                    check("idle_iss_b", iss_b, 32'd0);
                    check("idle_iss_tag", 32'(iss_tag) | 32'(iss_alu_op), 32'd0);
                end
            end
            if (mon_en && iss_valid === 1'b1 && iss_ready === 1'b1) begin
                if (iq.size() == 0) begin
                    check("unexpected_issue_tag", 32'(iss_tag), 32'hFFFF_FFFF);
                end else begin
                    e = iq.pop_front();
                    check("iss_alu_op", 32'(iss_alu_op), 32'(e.op));
                    check("iss_a",      iss_a,           e.a);
                    check("iss_b",      iss_b,           e.b);
                    check("iss_tag",    32'(iss_tag),    32'(e.tag));
                end
            end
        end
    end

    function automatic logic [TW-1:0] rand_tag();
        if ($urandom_range(0, 1) == 0) return '0;
        return TW'($urandom_range(1, 6));
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_alu_op = '0;
        disp_vj = '0; disp_qj = '0; disp_vk = '0; disp_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; iss_ready = 1'b0;
        @(posedge clk);
        #1;
        model_step();
        mon_en = 1'b1;

        // Independent operands: issue on the following cycle, then release
        disp(4'd1, 32'd5, 0, 32'd7, 0, 1);
        idle(1, 1);
        cdb(4'd1, 32'd12, 1);

        // Operand wakeup from the CDB
        disp(4'd3, 32'd0, 4'd2, 32'hF0, 0, 1);
        idle(2, 1);
        cdb(4'd2, 32'hFF, 1);
        idle(1, 1);
        cdb(4'd1, 32'h0, 1);

        // Dispatch-cycle bypass
        drive(0, 0, 1, 4'd2, 32'd0, 4'd3, 32'd9, 0, 1, 4'd3, 32'h1234, 1);
        idle(1, 1);
        cdb(4'd1, 32'h0, 1);

        // Fill, overflow dispatch, in-order drain, release of tag 2
        for (int i = 0; i < 5; i++) disp(4'(i + 1), 32'(i), 0, 32'(10 * i), 0, 0);
        idle(4, 1);
        cdb(4'd2, 32'h0, 0);
        idle(1, 0);
        for (int i = 1; i <= 4; i++) cdb(TW'(i), 32'h0, 0);

        // Flush with concurrent dispatch
        disp(4'd4, 32'd1, 0, 32'd2, 0, 1);
        disp(4'd5, 32'd1, 4'd6, 32'd2, 0, 0);
        disp(4'd6, 32'd1, 0, 32'd2, 4'd6, 0);
        drive(0, 1, 1, 4'd7, 32'd3, 0, 32'd4, 0, 0, 0, 0, 0);
        idle(2, 1);

        // Mid-stream reset followed by a stale CDB tag
        disp(4'd8, 32'd1, 0, 32'd2, 0, 0);
        disp(4'd9, 32'd1, 4'd5, 32'd2, 0, 1);
        drive(1, 0, 1, 4'd1, 32'd1, 0, 32'd1, 0, 1, 4'd5, 32'h55, 1);
        cdb(4'd1, 32'h77, 1);
        cdb(4'd5, 32'h66, 1);
        idle(1, 1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0), 4'($urandom_range(1, 12)),
                  $urandom, rand_tag(), $urandom, rand_tag(),
                  ($urandom_range(0, 4) < 3), TW'($urandom_range(0, 6)), $urandom,
                  ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        check("pending_issues", 32'(iq.size()), 32'd0);
        check("pending_cycles", 32'(sq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
